// File: rtl/cnt_rate_meter.sv
// Rate meter for a Gray-coded counter from a foreign clock domain: synchronises and
// decodes the count, reports its advance per WINDOW local cycles, and tracks the peak.
module cnt_rate_meter #(
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_max,
  input  logic [CNT_W-1:0] cnt_gray,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic [CNT_W-1:0] rate_max,
  output logic             busy
);

  localparam int              WC_W     = $clog2(WINDOW);
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, MEASURE = 2'd2} state_e;

  logic [SYNC_STAGES-1:0][CNT_W-1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_bin_q, cnt_bin_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             rate_valid_q, rate_valid_d;
  logic [CNT_W-1:0] rate_max_q, rate_max_d;
  logic             busy_q, busy_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] sync_last, delta;

  // Stage 0 captures the asynchronous input; only the last stage is decoded.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], cnt_gray};
    sync_last = sync_q[SYNC_STAGES-1];
    cnt_bin_d = '0;
    for (int i = 0; i < CNT_W; i++) cnt_bin_d[i] = ^(sync_last >> i);
    delta     = cnt_bin_q - base_q;
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    win_cnt_d    = win_cnt_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    rate_max_d   = rate_max_q;
    case (state_q)
      IDLE: begin
        win_cnt_d = '0;
        if (en) state_d = PRIME;
      end
      PRIME: begin
        base_d    = cnt_bin_q;
        win_cnt_d = '0;
        state_d   = en ? MEASURE : IDLE;
      end
      MEASURE: begin
        // A terminal count still reports even if en drops in the same cycle.
        if (win_cnt_q == WIN_LAST) begin
          rate_d       = delta;
          base_d       = cnt_bin_q;
          win_cnt_d    = '0;
          rate_valid_d = 1'b1;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
        if (!en) begin
          state_d   = IDLE;
          win_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Peak tracks the rate being presented; clr_max during that pulse restarts from it.
    if (rate_valid_q) begin
      if (clr_max || (rate_q > rate_max_q)) rate_max_d = rate_q;
    end else if (clr_max) begin
      rate_max_d = '0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      cnt_bin_q    <= '0;
      base_q       <= '0;
      win_cnt_q    <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      rate_max_q   <= '0;
      busy_q       <= 1'b0;
      state_q      <= IDLE;
    end else begin
      sync_q       <= sync_d;
      cnt_bin_q    <= cnt_bin_d;
      base_q       <= base_d;
      win_cnt_q    <= win_cnt_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      rate_max_q   <= rate_max_d;
      busy_q       <= busy_d;
      state_q      <= state_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign rate_max   = rate_max_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cnt_rate_meter.sv
// Directed bench for cnt_rate_meter: one WINDOW=256 instance and one WINDOW=64 instance
// sharing a bench-driven Gray source.
module tb_cnt_rate_meter;
  localparam int W   = 256;
  localparam int W64 = 64;

  logic       clk = 1'b0;
  logic       rst, en, en64, clr_max;
  logic [7:0] cnt_gray;
  logic [7:0] rate, rate_max, rate64, rmax64;
  logic       rate_valid, busy, rv64, busy64;

  int         n_chk = 0, n_fail = 0;
  logic [7:0] src_bin = 8'h00;
  int         src_step = 0, src_div = 0;

  cnt_rate_meter #(.CNT_W(8), .WINDOW(W), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr_max(clr_max), .cnt_gray(cnt_gray),
    .rate(rate), .rate_valid(rate_valid), .rate_max(rate_max), .busy(busy));

  cnt_rate_meter #(.CNT_W(8), .WINDOW(W64), .SYNC_STAGES(2)) u_dut64 (
    .clk(clk), .rst(rst), .en(en64), .clr_max(clr_max), .cnt_gray(cnt_gray),
    .rate(rate64), .rate_valid(rv64), .rate_max(rmax64), .busy(busy64));

  always #5 clk = ~clk;

  // Foreign source: one Gray step every src_step cycles, presented on the falling edge.
  initial begin
    cnt_gray = 8'h00;
    forever begin
      @(negedge clk);
      if (src_step > 0) begin
        src_div++;
        if (src_div >= src_step) begin
          src_div = 0;
          src_bin = src_bin + 8'd1;
        end
      end
      cnt_gray = src_bin ^ (src_bin >> 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [7:0] start);
    en = 1'b0; en64 = 1'b0; clr_max = 1'b0;
    src_step = 0; src_div = 0; src_bin = start;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Returns posedges elapsed until the selected rate_valid is seen, or -1 on timeout.
  task automatic wait_pulse(input bit sel64, input int limit, output int n);
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < limit) begin
      @(posedge clk); #1;
      n++;
      seen = sel64 ? rv64 : rate_valid;
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; en64 = 1'b0; clr_max = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({rate, rate_valid, rate_max, busy} !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {rate, rate_valid, rate_max, busy});
    end
    n_chk++;
    if ({rate64, rv64, rmax64, busy64} !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs64: got %h want 0", {rate64, rv64, rmax64, busy64});
    end
  endtask

  task automatic test_static();
    int n;
    do_reset(8'h37);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_pulse(1'b0, W + 10, n);
      n_chk++;
      if (n !== ((k == 0) ? W + 2 : W - 1)) begin
        n_fail++; $display("FAIL static_spacing%0d: got %0d want %0d", k, n, (k == 0) ? W + 2 : W - 1);
      end
      n_chk++;
      if (rate !== 8'd0) begin n_fail++; $display("FAIL static_rate%0d: got %0d want 0", k, rate); end
      @(posedge clk); #1;
      n_chk++;
      if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL static_pulse_width%0d: got %b want 0", k, rate_valid); end
      n_chk++;
      if (rate_max !== 8'd0) begin n_fail++; $display("FAIL static_max%0d: got %0d want 0", k, rate_max); end
    end
    en = 1'b0;
  endtask

  task automatic test_steady();
    int n;
    do_reset(8'h00);
    src_step = 4;
    repeat (12) @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL steady_busy_start: got %b want 1", busy); end
    for (int k = 0; k < 3; k++) begin
      wait_pulse(1'b0, W + 10, n);
      n_chk++;
      if (n !== ((k == 0) ? W + 1 : W - 1)) begin
        n_fail++; $display("FAIL steady_spacing%0d: got %0d want %0d", k, n, (k == 0) ? W + 1 : W - 1);
      end
      n_chk++;
      if (rate !== 8'd64) begin n_fail++; $display("FAIL steady_rate%0d: got %0d want 64", k, rate); end
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL steady_busy%0d: got %b want 1", k, busy); end
      @(posedge clk); #1;
      n_chk++;
      if (rate_max !== 8'd64) begin n_fail++; $display("FAIL steady_max%0d: got %0d want 64", k, rate_max); end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    do_reset(8'hF0);
    src_step = 2;
    repeat (8) @(posedge clk);
    #1 en64 = 1'b1;
    wait_pulse(1'b1, W64 + 10, n);
    n_chk++;
    if (n !== W64 + 2) begin n_fail++; $display("FAIL wrap_latency: got %0d want %0d", n, W64 + 2); end
    n_chk++;
    if (rate64 !== 8'd32) begin n_fail++; $display("FAIL wrap_rate: got %0d want 32", rate64); end
    @(posedge clk); #1;
    n_chk++;
    if (rmax64 !== 8'd32) begin n_fail++; $display("FAIL wrap_max: got %0d want 32", rmax64); end
    en64 = 1'b0;
  endtask

  task automatic test_enable_drop();
    int n, spurious;
    do_reset(8'h00);
    src_step = 4;
    repeat (12) @(posedge clk);
    #1 en = 1'b1;
    wait_pulse(1'b0, W + 10, n);
    n_chk++;
    if (rate !== 8'd64) begin n_fail++; $display("FAIL drop_prev_rate: got %0d want 64", rate); end
    repeat (100) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b want 0", busy); end
    n_chk++;
    if (rate !== 8'd64) begin n_fail++; $display("FAIL drop_rate_hold: got %0d want 64", rate); end
    spurious = 0;
    repeat (300) begin
      if (rate_valid !== 1'b0) spurious++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (spurious !== 0) begin n_fail++; $display("FAIL drop_no_pulse: got %0d pulses want 0", spurious); end
    en = 1'b1;
    wait_pulse(1'b0, W + 10, n);
    n_chk++;
    if (n !== W + 2) begin n_fail++; $display("FAIL drop_restart_latency: got %0d want %0d", n, W + 2); end
    n_chk++;
    if (rate !== 8'd64) begin n_fail++; $display("FAIL drop_restart_rate: got %0d want 64", rate); end
    en = 1'b0;
  endtask

  task automatic test_peak();
    int n;
    logic [7:0] vals [3]  = '{8'd10, 8'd40, 8'd20};
    logic [7:0] maxes [3] = '{8'd10, 8'd40, 8'd40};
    do_reset(8'h00);
    en = 1'b1;
    wait_pulse(1'b0, W + 10, n);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      repeat ((k < 3) ? int'(vals[k]) : 15) begin
        src_bin = src_bin + 8'd1;
        @(posedge clk); #1;
      end
      wait_pulse(1'b0, W + 10, n);
      n_chk++;
      if (rate !== ((k < 3) ? vals[k] : 8'd15)) begin
        n_fail++; $display("FAIL peak_rate%0d: got %0d want %0d", k, rate, (k < 3) ? vals[k] : 8'd15);
      end
      if (k == 3) begin
        n_chk++;
        if (rate_max !== 8'd40) begin n_fail++; $display("FAIL peak_max_before_clr: got %0d want 40", rate_max); end
        clr_max = 1'b1;
      end
      @(posedge clk); #1;
      clr_max = 1'b0;
      n_chk++;
      if (rate_max !== ((k < 3) ? maxes[k] : 8'd15)) begin
        n_fail++; $display("FAIL peak_max%0d: got %0d want %0d", k, rate_max, (k < 3) ? maxes[k] : 8'd15);
      end
    end
    clr_max = 1'b1;
    @(posedge clk); #1;
    clr_max = 1'b0;
    n_chk++;
    if (rate_max !== 8'd0) begin n_fail++; $display("FAIL peak_clr_alone: got %0d want 0", rate_max); end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    do_reset(8'h00);
    src_step = 4;
    repeat (12) @(posedge clk);
    #1 en = 1'b1;
    wait_pulse(1'b0, W + 10, n);
    repeat (50) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_chk++;
    if ({rate, rate_valid, rate_max, busy} !== 18'd0) begin
      n_fail++; $display("FAIL async_rst_outputs: got %h want 0", {rate, rate_valid, rate_max, busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_pulse(1'b0, W + 10, n);
    n_chk++;
    if (n !== W + 2) begin n_fail++; $display("FAIL async_rst_restart: got %0d want %0d", n, W + 2); end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en64 = 1'b0; clr_max = 1'b0;
    #1;
    test_reset();
    test_static();
    test_steady();
    test_wrap();
    test_enable_drop();
    test_peak();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
